// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator.
// Captures one accepted MIDI channel event, scans the voice pool one voice per
// cycle to find a matching, free and oldest voice, then commits the result.
module voice_alloc #(
    parameter int         VOICES  = 4,
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            ch_message,
    input  logic [3:0]            chan,
    input  logic [6:0]            note,
    input  logic [6:0]            velocity,
    input  logic [6:0]            lsb,
    output logic [VOICES-1:0]     gate,
    output logic [7*VOICES-1:0]   voice_note,
    output logic [7*VOICES-1:0]   voice_vel,
    output logic [VOICES-1:0]     trig,
    output logic                  steal,
    output logic                  busy,
    output logic                  drop
);

    localparam int             IW   = $clog2(VOICES);
    localparam logic [IW-1:0]  LAST = IW'(VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;
    typedef enum logic [1:0] {C_ON, C_OFF, C_ALL} cls_t;

    state_t                   state_q, state_d;
    cls_t                     cls_q, cls_d;
    logic [6:0]               cap_note_q, cap_note_d;
    logic [6:0]               cap_vel_q, cap_vel_d;
    logic [IW-1:0]            idx_q, idx_d;

    // scan results
    logic                     match_vld_q, match_vld_d;
    logic [IW-1:0]            match_idx_q, match_idx_d;
    logic                     free_vld_q, free_vld_d;
    logic [IW-1:0]            free_idx_q, free_idx_d;
    logic                     old_vld_q, old_vld_d;
    logic [IW-1:0]            old_idx_q, old_idx_d;
    logic [7:0]               old_age_q, old_age_d;

    // voice pool
    logic [VOICES-1:0]        gate_q, gate_d;
    logic [VOICES-1:0][6:0]   note_q, note_d;
    logic [VOICES-1:0][6:0]   vel_q, vel_d;
    logic [VOICES-1:0][7:0]   stamp_q, stamp_d;
    logic [7:0]               cnt_q, cnt_d;

    logic [VOICES-1:0]        trig_q, trig_d;
    logic                     steal_q, steal_d;
    logic                     busy_q, busy_d;
    logic                     drop_q, drop_d;

    logic                     type_ok, accept;
    logic                     go;
    logic [7:0]               age;
    logic [IW-1:0]            tgt;

    assign type_ok = (ch_message == 4'h8) || (ch_message == 4'h9) || (ch_message == 4'hB);
    assign accept  = type_ok && (OMNI || (chan == CHANNEL));

    assign gate       = gate_q;
    assign voice_note = note_q;
    assign voice_vel  = vel_q;
    assign trig       = trig_q;
    assign steal      = steal_q;
    assign busy       = busy_q;
    assign drop       = drop_q;

    // Next-state: event capture, per-voice scan, and commit of the chosen action
    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        cap_note_d  = cap_note_q;
        cap_vel_d   = cap_vel_q;
        idx_d       = idx_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        old_vld_d   = old_vld_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        gate_d      = gate_q;
        note_d      = note_q;
        vel_d       = vel_q;
        stamp_d     = stamp_q;
        cnt_d       = cnt_q;
        trig_d      = '0;
        steal_d     = 1'b0;
        busy_d      = busy_q;
        drop_d      = 1'b0;
        go          = 1'b0;
        tgt         = '0;
        age         = cnt_q - stamp_q[idx_q];

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (ch_message == 4'h9 && velocity != 7'd0) begin
                        cls_d = C_ON;
                        go    = 1'b1;
                    end else if (ch_message == 4'h8 || ch_message == 4'h9) begin
                        cls_d = C_OFF;
                        go    = 1'b1;
                    end else if (lsb == 7'd123) begin
                        cls_d = C_ALL;
                        go    = 1'b1;
                    end
                end
                if (go) begin
                    cap_note_d  = note;
                    cap_vel_d   = velocity;
                    idx_d       = '0;
                    match_vld_d = 1'b0;
                    free_vld_d  = 1'b0;
                    old_vld_d   = 1'b0;
                    old_age_d   = '0;
                    busy_d      = 1'b1;
                    state_d     = (cls_d == C_ALL) ? S_COMMIT : S_SCAN;
                end
            end
            S_SCAN: begin
                drop_d = accept;
                if (gate_q[idx_q]) begin
                    if (!match_vld_q && note_q[idx_q] == cap_note_q) begin
                        match_vld_d = 1'b1;
                        match_idx_d = idx_q;
                    end
                    // strict compare keeps the lowest index on equal age
                    if (!old_vld_q || age > old_age_q) begin
                        old_vld_d = 1'b1;
                        old_idx_d = idx_q;
                        old_age_d = age;
                    end
                end else if (!free_vld_q) begin
                    free_vld_d = 1'b1;
                    free_idx_d = idx_q;
                end
                if (idx_q == LAST) state_d = S_COMMIT;
                else               idx_d   = idx_q + 1'b1;
            end
            S_COMMIT: begin
                drop_d  = accept;
                state_d = S_IDLE;
                busy_d  = 1'b0;
                case (cls_q)
                    C_ON: begin
                        if (match_vld_q)     tgt = match_idx_q;
                        else if (free_vld_q) tgt = free_idx_q;
                        else begin
                            tgt     = old_idx_q;
                            steal_d = 1'b1;
                        end
                        gate_d[tgt]  = 1'b1;
                        note_d[tgt]  = cap_note_q;
                        vel_d[tgt]   = cap_vel_q;
                        stamp_d[tgt] = cnt_q;
                        trig_d[tgt]  = 1'b1;
                        cnt_d        = cnt_q + 8'd1;
                    end
                    C_OFF: begin
                        if (match_vld_q) gate_d[match_idx_q] = 1'b0;
                    end
                    C_ALL: gate_d = '0;
                    default: ;
                endcase
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; async reset drops any pending event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cls_q       <= C_ON;
            cap_note_q  <= '0;
            cap_vel_q   <= '0;
            idx_q       <= '0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            old_vld_q   <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
            gate_q      <= '0;
            note_q      <= '0;
            vel_q       <= '0;
            stamp_q     <= '0;
            cnt_q       <= '0;
            trig_q      <= '0;
            steal_q     <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            cap_note_q  <= cap_note_d;
            cap_vel_q   <= cap_vel_d;
            idx_q       <= idx_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            old_vld_q   <= old_vld_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            gate_q      <= gate_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            stamp_q     <= stamp_d;
            cnt_q       <= cnt_d;
            trig_q      <= trig_d;
            steal_q     <= steal_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed scenarios with literal expectations plus random
// event traffic, all checked every cycle against an event-level voice model.
`timescale 1ns/1ps
module tb_voice_alloc;

    localparam int V = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       ch_message = '0;
    logic [3:0]       chan = '0;
    logic [6:0]       note = '0;
    logic [6:0]       velocity = '0;
    logic [6:0]       lsb = '0;
    logic [V-1:0]     gate;
    logic [7*V-1:0]   voice_note;
    logic [7*V-1:0]   voice_vel;
    logic [V-1:0]     trig;
    logic             steal;
    logic             busy;
    logic             drop;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    voice_alloc #(.VOICES(V), .CHANNEL(4'd0), .OMNI(1'b0)) dut (
        .clk(clk), .rst(rst), .ch_message(ch_message), .chan(chan),
        .note(note), .velocity(velocity), .lsb(lsb),
        .gate(gate), .voice_note(voice_note), .voice_vel(voice_vel),
        .trig(trig), .steal(steal), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Voices are tracked as plain arrays; "oldest" is the front-most active
    // voice in an assignment-order list (least recently assigned).
    bit         m_gate[V];
    logic [6:0] m_note[V];
    logic [6:0] m_vel[V];
    int         order[$];
    bit         m_pend;
    int         m_cls;           // 0 on, 1 off, 2 all-off
    logic [6:0] m_cn, m_cv;
    longint     edge_no;
    longint     m_commit;
    logic [V-1:0] e_trig;
    bit         e_steal, e_busy, e_drop;

    task automatic model_reset();
        for (int i = 0; i < V; i++) begin
            m_gate[i] = 1'b0;
            m_note[i] = '0;
            m_vel[i]  = '0;
        end
        order.delete();
        m_pend = 1'b0;
        e_trig = '0;
        e_steal = 1'b0;
        e_busy = 1'b0;
        e_drop = 1'b0;
    endtask

    task automatic model_commit();
        int mt, ft, ot, t;
        mt = -1; ft = -1; ot = -1;
        for (int i = 0; i < V; i++) begin
            if (m_gate[i] && m_note[i] == m_cn && mt < 0) mt = i;
            if (!m_gate[i] && ft < 0) ft = i;
        end
        for (int k = 0; k < order.size(); k++)
            if (ot < 0 && m_gate[order[k]]) ot = order[k];
        if (m_cls == 0) begin
            t = (mt >= 0) ? mt : (ft >= 0) ? ft : ot;
            e_steal = (mt < 0 && ft < 0);
            m_gate[t] = 1'b1;
            m_note[t] = m_cn;
            m_vel[t]  = m_cv;
            e_trig[t] = 1'b1;
            for (int k = 0; k < order.size(); k++)
                if (order[k] == t) begin
                    order.delete(k);
                    break;
                end
            order.push_back(t);
        end else if (m_cls == 1) begin
            if (mt >= 0) m_gate[mt] = 1'b0;
        end else begin
            for (int i = 0; i < V; i++) m_gate[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit acc, was;
        edge_no++;
        e_trig = '0;
        e_steal = 1'b0;
        e_drop = 1'b0;
        acc = (ch_message inside {4'h8, 4'h9, 4'hB}) && chan == 4'd0;
        was = m_pend;
        if (acc && was) e_drop = 1'b1;
        if (m_pend && edge_no == m_commit) begin
            model_commit();
            m_pend = 1'b0;
        end else if (!was && acc) begin
            m_cn = note;
            m_cv = velocity;
            if (ch_message == 4'h9 && velocity != 0) begin
                m_cls = 0; m_pend = 1'b1; m_commit = edge_no + V + 1;
            end else if (ch_message != 4'hB) begin
                m_cls = 1; m_pend = 1'b1; m_commit = edge_no + V + 1;
            end else if (lsb == 7'd123) begin
                m_cls = 2; m_pend = 1'b1; m_commit = edge_no + 1;
            end
        end
        e_busy = m_pend;
    endtask

    initial begin
        model_reset();
        edge_no = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [V-1:0]   eg;
        logic [7*V-1:0] en, ev;
        for (int i = 0; i < V; i++) begin
            eg[i]         = m_gate[i];
            en[7*i +: 7]  = m_note[i];
            ev[7*i +: 7]  = m_vel[i];
        end
        check("gate", 64'(gate), 64'(eg));
        check("voice_note", 64'(voice_note), 64'(en));
        check("voice_vel", 64'(voice_vel), 64'(ev));
        check("trig", 64'(trig), 64'(e_trig));
        check("steal", 64'(steal), 64'(e_steal));
        check("busy", 64'(busy), 64'(e_busy));
        check("drop", 64'(drop), 64'(e_drop));
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) compare_all();
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_edges(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // drive one event for one cycle; returns just after its capture edge
    task automatic send(logic [3:0] m, logic [3:0] c, logic [6:0] n, logic [6:0] v, logic [6:0] l);
        @(posedge clk); #2;
        ch_message = m; chan = c; note = n; velocity = v; lsb = l;
        @(posedge clk); #2;
        ch_message = '0;
    endtask

    task automatic settle();
        wait_edges(V + 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        int gap, r;
        logic [3:0] m, c;
        logic [6:0] n, v, l;

        wait_edges(2);
        rst = 1'b0;
        chk_en = 1'b1;
        wait_edges(1);
        check("reset gate", 64'(gate), 64'h0);
        check("reset busy", 64'(busy), 64'h0);

        // single note-on timing
        send(4'h9, 4'd0, 7'd60, 7'd100, 7'd0);
        check("on busy e1", 64'(busy), 64'h1);
        wait_edges(4);
        check("on busy e5", 64'(busy), 64'h1);
        check("on gate e5", 64'(gate), 64'h0);
        wait_edges(1);
        check("on gate e6", 64'(gate), 64'h1);
        check("on note e6", 64'(voice_note[6:0]), 64'd60);
        check("on trig e6", 64'(trig), 64'h1);
        check("on busy e6", 64'(busy), 64'h0);
        wait_edges(1);
        check("on trig e7", 64'(trig), 64'h0);

        // fill pool then steal oldest
        do_reset();
        send(4'h9, 4'd0, 7'd60, 7'd100, 7'd0); settle();
        send(4'h9, 4'd0, 7'd62, 7'd100, 7'd0); settle();
        send(4'h9, 4'd0, 7'd64, 7'd100, 7'd0); settle();
        send(4'h9, 4'd0, 7'd65, 7'd100, 7'd0); settle();
        check("fill steal pre", 64'(steal), 64'h0);
        send(4'h9, 4'd0, 7'd67, 7'd100, 7'd0); settle();
        check("steal gate", 64'(gate), 64'hF);
        check("steal note0", 64'(voice_note[6:0]), 64'd67);
        check("steal note1", 64'(voice_note[13:7]), 64'd62);
        check("steal pulse", 64'(steal), 64'h1);
        check("steal trig", 64'(trig), 64'h1);

        // note-off forms
        do_reset();
        send(4'h9, 4'd0, 7'd60, 7'd100, 7'd0); settle();
        send(4'h9, 4'd0, 7'd60, 7'd0, 7'd0); settle();
        check("off vel0 gate", 64'(gate), 64'h0);
        check("off vel0 note", 64'(voice_note[6:0]), 64'd60);
        send(4'h9, 4'd0, 7'd60, 7'd100, 7'd0); settle();
        send(4'h8, 4'd0, 7'd60, 7'd64, 7'd0); settle();
        check("off 8 gate", 64'(gate), 64'h0);
        send(4'h9, 4'd0, 7'd60, 7'd100, 7'd0); settle();
        send(4'h8, 4'd0, 7'd70, 7'd64, 7'd0); settle();
        check("off unheld gate", 64'(gate), 64'h1);

        // retrigger same note
        do_reset();
        send(4'h9, 4'd0, 7'd60, 7'd50, 7'd0); settle();
        send(4'h9, 4'd0, 7'd60, 7'd90, 7'd0); settle();
        check("retrig vel", 64'(voice_vel[6:0]), 64'd90);
        check("retrig trig", 64'(trig), 64'h1);
        check("retrig gate", 64'(gate), 64'h1);
        check("retrig steal", 64'(steal), 64'h0);

        // all notes off, other CC ignored
        do_reset();
        send(4'h9, 4'd0, 7'd60, 7'd100, 7'd0); settle();
        send(4'h9, 4'd0, 7'd61, 7'd100, 7'd0); settle();
        send(4'h9, 4'd0, 7'd62, 7'd100, 7'd0); settle();
        check("three held", 64'(gate), 64'h7);
        send(4'hB, 4'd0, 7'd0, 7'd0, 7'd123);
        wait_edges(1);
        check("alloff gate", 64'(gate), 64'h0);
        check("alloff busy", 64'(busy), 64'h0);
        send(4'hB, 4'd0, 7'd0, 7'd0, 7'd7);
        check("cc7 busy", 64'(busy), 64'h0);

        // wrong channel, drop, reset mid-scan
        do_reset();
        send(4'h9, 4'd5, 7'd60, 7'd100, 7'd0); settle();
        check("ch5 gate", 64'(gate), 64'h0);
        send(4'h9, 4'd0, 7'd60, 7'd100, 7'd0);
        send(4'h9, 4'd0, 7'd62, 7'd100, 7'd0);
        check("drop pulse", 64'(drop), 64'h1);
        settle();
        check("drop gate", 64'(gate), 64'h1);
        check("drop note0", 64'(voice_note[6:0]), 64'd60);
        send(4'h9, 4'd0, 7'd64, 7'd100, 7'd0);
        wait_edges(1);
        rst = 1'b1;
        #1;
        check("rst gate", 64'(gate), 64'h0);
        check("rst busy", 64'(busy), 64'h0);
        check("rst note", 64'(voice_note), 64'h0);
        @(posedge clk); #2;
        rst = 1'b0;

        // random traffic checked by the model
        for (int k = 0; k < 150; k++) begin
            gap = $urandom_range(0, 9);
            if (gap > 0) wait_edges(gap);
            r = $urandom_range(0, 9);
            c = ($urandom_range(0, 15) == 0) ? 4'd3 : 4'd0;
            n = 7'(60 + $urandom_range(0, 5));
            v = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            l = ($urandom_range(0, 1) == 0) ? 7'd123 : 7'd7;
            if (r <= 4)      m = 4'h9;
            else if (r <= 6) m = 4'h8;
            else if (r == 7) m = 4'hB;
            else if (r == 8) m = 4'hA;
            else begin
                m = 4'h9;
                c = 4'd5;
            end
            send(m, c, n, v, l);
        end
        wait_edges(2 * V + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/voice_alloc.md
# voice_alloc

Polyphonic voice allocator between the MIDI receiver and the synth voice bank. It consumes the single-cycle decoded channel messages (ch_message, chan, note, velocity, lsb) and assigns note-on events to a fixed pool of VOICES voices. It releases voices on note-off and steals the oldest voice when the pool is full. Per-voice gate, note, velocity and trigger outputs drive the oscillators/envelopes directly.

## Interface
- VOICES, 4: number of voices, 2..8.
- CHANNEL, 4'd0: MIDI channel listened to, 0-based.
- OMNI, 0: 1 = accept all channels, CHANNEL ignored.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; one clock, asynchronous and active-high.
- ch_message  in  4  message high nibble; nonzero only in the cycle a message is valid.
- chan  in  4  message channel.
- note  in  7  note number (note on/off).
- velocity  in  7  velocity.
- lsb  in  7  second byte (controller number for CC).
- gate  out  VOICES  per-voice gate, bit i = voice i sounding.
- voice_note  out  7*VOICES  note of voice i at [7i+6:7i].
- voice_vel  out  7*VOICES  velocity of voice i at [7i+6:7i].
- trig  out  VOICES  one-cycle pulse when voice i is (re)assigned by a note-on.
- steal  out  1  one-cycle pulse, coincident with trig, when an active voice was stolen.
- busy  out  1  allocator processing an event.
- drop  out  1  one-cycle pulse when an accepted-type event arrived while busy.

## Operation
- Event accepted when ch_message ∈ {4'h8, 4'h9, 4'hB} and (OMNI or chan==CHANNEL); everything else ignored.
- Classification at capture:
  - 9 with velocity≠0 → ON.
  - 8, or 9 with velocity==0 → OFF.
  - B with lsb==123 → ALL_OFF.
  - Other B ignored.
- Captured note/velocity/class held in internal registers; inputs not used after capture.
- FSM states:
  - IDLE: accepted event → SCAN, scan index 0.
  - SCAN: examines voice[index] once per cycle, index 0..VOICES-1, then → COMMIT.
  - COMMIT: applies the result, → IDLE.
  - ALL_OFF skips SCAN (IDLE → COMMIT).
- Per voice state: gate, note, vel, 8-bit stamp. Global 8-bit alloc counter, incremented modulo 256 on every committed ON.
- SCAN bookkeeping:
  - match = lowest active voice with same note.
  - free = lowest-index inactive voice.
  - oldest = active voice with largest (counter − stamp) mod 256; ties go to the lowest index.
- ON target priority: match (retrigger), else free, else oldest (steal).
- ON commit on target: gate=1, note, vel, stamp=counter, trig pulse. steal=1 only in the oldest case.
- OFF commit: if match exists, gate=0; note/vel retained. No match → no change.
- ALL_OFF commit: all gates 0.
- Stamp ambiguity after 256 further allocations on a held voice is accepted.

## Timing
- Reset values: gate=0, voice_note=0, voice_vel=0, stamps=0, counter=0, trig=0, steal=0, busy=0, drop=0, FSM=IDLE.
- Event valid in cycle 0 is captured at edge 1; busy high from edge 1.
- SCAN occupies edges 2..VOICES+1. COMMIT edge is VOICES+2: gate/note/vel update there, trig/steal high for the following cycle, busy falls there.
- ALL_OFF: commit at edge 2.
- Accepted event in any cycle with busy=1: discarded, drop high for one cycle, state unaffected.
- Events on the commit-exit cycle (busy still high) are dropped. MIDI spacing (≥16000 clocks per message) makes drops a fault indicator only.
- Async reset mid-scan: immediate return to reset values, pending event lost.

## Test plan
- Reset, then ON note 60 vel 100 ch0 (VOICES=4) → at edge 6 gate=0001, voice_note[6:0]=60, trig=0001 one cycle, busy high edges 1..5.
- ON 60, 62, 64, 65, then ON 67 → voices 0..3 filled in order; fifth steals voice 0: gate=1111, voice 0 note 67, steal=1, trig=0001.
- ON 60 then ON ch0 note 60 vel 0 → gate bit 0 cleared, voice_note still 60. Repeat with ch_message=8 → same result. OFF for unheld note 70 → no change.
- ON 60 vel 50, then ON 60 vel 90 → same voice 0 retriggered, vel=90, trig=0001, gate=0001, steal=0.
- Three ONs held, then CC lsb=123 → gate=0000 at edge 2. CC lsb=7 → ignored, busy stays 0.
- ON on ch5 with CHANNEL=0, OMNI=0 → ignored. Second ON two cycles after first → drop pulse, only first assigned. Assert rst during SCAN → all outputs 0 immediately.
